// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Turns debounced button levels into timed events (PRESS, RELEASE, LONG,
//   REPEAT). Each button owns one pending slot; a round-robin arbiter moves
//   at most one pending event per cycle into a show-ahead event FIFO that the
//   consumer drains with a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_in     debounced button levels (1 = pressed), synchronous to clk
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer takes the head when evt_valid & evt_ready
//   evt_id     button index of the head event (0 while evt_valid = 0)
//   evt_code   0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT (0 while evt_valid = 0)
//   evt_ovf    sticky flag: an event was dropped
//   ovf_clr    single-cycle clear of evt_ovf (a same-cycle drop wins)
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic [1:0]               evt_code,
  output logic                     evt_ovf,
  input  logic                     ovf_clr
);

  localparam int ID_W   = $clog2(N_BTN);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] CODE_PRESS   = 2'd0;
  localparam logic [1:0] CODE_RELEASE = 2'd1;
  localparam logic [1:0] CODE_LONG    = 2'd2;
  localparam logic [1:0] CODE_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_e;

  logic [TCNT_W-1:0] tcnt_q;
  logic              tick_q;
  logic [N_BTN-1:0]  btn_q;

  state_e            state_q [N_BTN];
  state_e            state_d [N_BTN];
  logic [7:0]        hcnt_q  [N_BTN];
  logic [7:0]        hcnt_d  [N_BTN];

  logic [N_BTN-1:0]  pend_v_q, pend_v_d;
  logic [1:0]        pend_code_q [N_BTN];
  logic [1:0]        pend_code_d [N_BTN];

  logic [ID_W-1:0]   rr_q, rr_d, gnt;
  logic              gnt_found, push, pop, drop;
  logic              ovf_q, ovf_d;

  logic [ID_W+1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;

  // Index base+off, wrapped into 0..N_BTN-1 (N_BTN need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_BTN) s = s - N_BTN;
    return ID_W'(s);
  endfunction

  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid & evt_ready;
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign evt_id    = evt_valid ? mem[rd_q][ID_W+1:2] : '0;
  assign evt_code  = evt_valid ? mem[rd_q][1:0]      : '0;
  assign evt_ovf   = ovf_q;

  always_comb begin
    logic       rise, fall, post;
    logic [1:0] code;
    rise      = 1'b0;
    fall      = 1'b0;
    post      = 1'b0;
    code      = CODE_PRESS;
    drop      = 1'b0;
    gnt_found = 1'b0;
    gnt       = '0;
    pend_v_d  = pend_v_q;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]     = state_q[i];
      hcnt_d[i]      = hcnt_q[i];
      pend_code_d[i] = pend_code_q[i];
    end

    // Round-robin search starting at rr_q.
    for (int k = 0; k < N_BTN; k++) begin
      if (!gnt_found && pend_v_q[wrap_idx(rr_q, k)]) begin
        gnt_found = 1'b1;
        gnt       = wrap_idx(rr_q, k);
      end
    end
    push = gnt_found && (cnt_q != (AW+1)'(FIFO_DEPTH));
    rr_d = rr_q;
    if (push) begin
      pend_v_d[gnt] = 1'b0;
      rr_d = (gnt == ID_W'(N_BTN-1)) ? '0 : gnt + 1'b1;
    end

    for (int i = 0; i < N_BTN; i++) begin
      rise = btn_in[i] & ~btn_q[i];
      fall = ~btn_in[i] & btn_q[i];
      post = 1'b0;
      code = CODE_PRESS;
      case (state_q[i])
        S_IDLE: begin
          if (rise) begin
            state_d[i] = S_PRESSED;
            hcnt_d[i]  = '0;
            post       = 1'b1;
            code       = CODE_PRESS;
          end
        end
        S_PRESSED: begin
          if (fall) begin
            state_d[i] = S_IDLE;
            post       = 1'b1;
            code       = CODE_RELEASE;
          end else if (tick_q) begin
            if (hcnt_q[i] == 8'(LONG_TICKS-1)) begin
              state_d[i] = S_HELD;
              hcnt_d[i]  = '0;
              post       = 1'b1;
              code       = CODE_LONG;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 8'd1;
            end
          end
        end
        S_HELD: begin
          if (fall) begin
            state_d[i] = S_IDLE;
            post       = 1'b1;
            code       = CODE_RELEASE;
          end else if (tick_q) begin
            if (hcnt_q[i] == 8'(REPEAT_TICKS-1)) begin
              hcnt_d[i] = '0;
              post      = 1'b1;
              code      = CODE_REPEAT;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 8'd1;
            end
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      // pend_v_d already reflects this cycle's grant, so a slot freed by the
      // arbiter can take the new event immediately.
      if (post) begin
        if (pend_v_d[i]) begin
          drop = 1'b1;
        end else begin
          pend_v_d[i]    = 1'b1;
          pend_code_d[i] = code;
        end
      end
    end

    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q   <= '0;
      tick_q   <= 1'b0;
      btn_q    <= '0;
      pend_v_q <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_IDLE;
        hcnt_q[i]  <= '0;
      end
    end else begin
      if (tcnt_q == TCNT_W'(TICK_DIV-1)) begin
        tcnt_q <= '0;
        tick_q <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
        tick_q <= 1'b0;
      end
      btn_q    <= btn_in;
      pend_v_q <= pend_v_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Event payload storage; qualified by pend_v_q and cnt_q.
  always_ff @(posedge clk) begin
    pend_code_q <= pend_code_d;
    if (push) mem[wr_q] <= {gnt, pend_code_q[gnt]};
  end

endmodule

// File: doc/btn_event_ctrl.md
# btn_event_ctrl

Button event controller for the FPGA front panel. Takes up to N_BTN already-synchronized, debounced button levels (one per button filter instance) and turns them into timed events: press, release, long-press and auto-repeat. A round-robin arbiter shares a single event FIFO among the buttons, and the game/UI logic drains it through a valid/ready handshake.

## Interface
- N_BTN, 4: number of button inputs (2..8)
- TICK_DIV, 1_000_000: clk cycles per timing tick (100 Hz at 100 MHz)
- LONG_TICKS, 100: ticks held before the LONG event
- REPEAT_TICKS, 20: ticks between REPEAT events while held
- FIFO_DEPTH, 4: event FIFO entries (power of two)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_in  in  N_BTN  debounced button levels, 1 = pressed, synchronous to clk
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_id  out  clog2(N_BTN)  button index of head event
- evt_code  out  2  0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
- evt_ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  single-cycle clear of evt_ovf

## Operation
- Tick generator: counter 0..TICK_DIV-1. `tick` pulses for one cycle when the counter wraps to 0.
- Edge detect: `btn_q` registers btn_in. rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
- Each button runs its own FSM with an 8-bit hold counter `hcnt`:
  - IDLE: on rise, go to PRESSED, set hcnt=0, post PRESS.
  - PRESSED: on fall, go to IDLE, post RELEASE. Otherwise, on tick, hcnt++. When tick arrives with hcnt==LONG_TICKS-1, go to HELD, set hcnt=0, post LONG.
  - HELD: on fall, go to IDLE, post RELEASE. Otherwise, on tick, hcnt++. When tick arrives with hcnt==REPEAT_TICKS-1, set hcnt=0 and post REPEAT.
  - fall takes precedence over tick in the same cycle.
- Post: writes code into the button's single pending slot (pend_v, pend_code).
  - If pend_v is already set, the new event is dropped and evt_ovf is set. The pending event is kept.
- Arbiter: every cycle where the FIFO is not full and any pend_v is set, grant the first pending index at or after `rr_ptr`, searching upward and wrapping.
  - Push {id, code} into the FIFO and clear that pend_v.
  - Set rr_ptr = grant+1 mod N_BTN.
  - At most one push per cycle.
- A slot cleared by a grant and re-posted in the same cycle holds the new event (clear first, then set).
- FIFO: show-ahead.
  - evt_id and evt_code are valid whenever evt_valid=1 and stay stable until the pop.
  - Push and pop may happen in the same cycle unless the FIFO is full. When full, no push occurs and the pops drain it.
  - When empty, the FIFO is not bypassed.
- evt_ovf: set has priority over ovf_clr in the same cycle.
- Reset:
  - All FSMs go to IDLE, hcnt=0, btn_q=0, pend_v=0, rr_ptr=0.
  - FIFO empty, tick counter 0.
  - Outputs: evt_valid=0, evt_id=0, evt_code=0, evt_ovf=0.
  - Reset mid-operation discards all queued and pending events.
  - A button held through reset produces PRESS on the first cycle after reset, because btn_q=0.

## Timing
- Latency, with FIFO empty and no contention:
  - btn_in is first sampled high at edge E0.
  - The PRESS slot is set at E0.
  - The FIFO push happens at E1.
  - evt_valid=1 after E1, so it is visible in cycle E1..E2.
- Long press: LONG is posted on the LONG_TICKS-th tick after entering PRESSED. Hold time is LONG_TICKS×TICK_DIV cycles, give or take one tick of phase.
- Repeats: REPEAT is posted every REPEAT_TICKS ticks in HELD.
- Throughput: one event per cycle in and out.
- Contention: with all N_BTN buttons pending, the N_BTN events drain in N_BTN consecutive cycles, in round-robin order.
- Backpressure: with evt_ready=0, pending slots hold. A second event per button while blocked is dropped and evt_ovf is set.

## Test plan
Test parameters: TICK_DIV=10, LONG_TICKS=3, REPEAT_TICKS=2, FIFO_DEPTH=4, N_BTN=4, evt_ready=1 unless noted.
- Press and release: btn_in[2] high for 15 cycles, then low -> events {2,PRESS}, then {2,RELEASE}. No LONG. evt_valid rises 2 edges after the rise is sampled.
- Long and repeat: btn_in[0] held for 80 cycles -> PRESS, LONG after about 30 cycles, REPEAT every 20 cycles (2 REPEATs), then RELEASE on drop. evt_ovf=0.
- Arbitration: btn_in=4'b1111 in one cycle from reset -> PRESS ids 0,1,2,3 on consecutive cycles. Then, with rr_ptr=0, btn_in[3] and btn_in[1] fall together -> RELEASE for id 1 before id 3.
- Backpressure and overflow: evt_ready=0, press and release btn 0 three times -> FIFO full (4), pending slot holds the 5th event, evt_ovf=1. Set evt_ready=1 -> 5 events drain in order. Pulse ovf_clr -> evt_ovf=0.
- Reset mid-operation: queue 3 events, assert rst for 1 cycle with btn_in[1] held -> evt_valid=0 and outputs zero during reset, then a single {1,PRESS} after reset.
- Simultaneous push and pop: FIFO at 2 entries, push and pop in the same cycle -> count stays 2 and the order is preserved.
